// File: rtl/qsn_pkg.sv
// qsn_pkg: shared constants and state type for the QSN shift scheduler
// Z       : circulant size (network width)
// SEL_W   : shift select width, ceil(log2 Z)
// DEPTH   : shift-table entries, IDX_W = log2 DEPTH
// NET_LAT : cycles from network input to registered network output
package qsn_pkg;
   localparam int Z       = 255;
   localparam int SEL_W   = 8;
   localparam int DEPTH   = 16;
   localparam int IDX_W   = 4;
   localparam int NET_LAT = 2;
   localparam int CNT_W   = $clog2(NET_LAT + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
endpackage

// File: rtl/qsn_sel_gen.sv
// qsn_sel_gen: maps a circulant shift amount to the QSN network selects
// shift_i     : shift amount s, 0..Z-1
// left_sel_o  : s
// right_sel_o : (Z-s) mod Z
// merge_sel_o : bit k takes the left path when k < Z-s
module qsn_sel_gen
   import qsn_pkg::*;
(
   input  logic [SEL_W-1:0] shift_i,
   output logic [SEL_W-1:0] left_sel_o,
   output logic [SEL_W-1:0] right_sel_o,
   output logic [Z-2:0]     merge_sel_o
);
   assign left_sel_o  = shift_i;
   assign right_sel_o = (shift_i == '0) ? '0 : SEL_W'(Z) - shift_i;
   // k < Z-s rewritten as k+s < Z to stay unsigned
   for (genvar k = 0; k < Z - 1; k++) begin : g_merge
      assign merge_sel_o[k] = ({1'b0, shift_i} + (SEL_W+1)'(k)) < (SEL_W+1)'(Z);
   end
endmodule

// File: rtl/qsn_shift_scheduler.sv
// qsn_shift_scheduler: walks a per-layer shift table and sequences the QSN network
// sys_clk, rstn                 : clock, synchronous active-low reset
// cfg_we_i/addr_i/shift_i       : table write port, accepted only when idle and shift < Z
// cfg_len_i, start_i            : run length and run request
// issue_en_i                    : feeder ready, stalls issuing only
// busy_o, done_o, cfg_err_o     : run status, end-of-layer pulse, rejected write/start pulse
// in_valid_o/in_idx_o/*_sel_o   : registered selects for the entry entering the network
// out_valid_o/out_idx_o         : entry currently valid at the network output
module qsn_shift_scheduler
   import qsn_pkg::*;
(
   input  logic             sys_clk,
   input  logic             rstn,
   input  logic             cfg_we_i,
   input  logic [IDX_W-1:0] cfg_addr_i,
   input  logic [SEL_W-1:0] cfg_shift_i,
   input  logic [IDX_W:0]   cfg_len_i,
   input  logic             start_i,
   input  logic             issue_en_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             cfg_err_o,
   output logic             in_valid_o,
   output logic [IDX_W-1:0] in_idx_o,
   output logic [SEL_W-1:0] left_sel_o,
   output logic [SEL_W-1:0] right_sel_o,
   output logic [Z-2:0]     merge_sel_o,
   output logic             out_valid_o,
   output logic [IDX_W-1:0] out_idx_o
);
   state_t           state_q;
   logic [IDX_W:0]   len_q;
   logic [IDX_W-1:0] ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic [SEL_W-1:0] tbl_q [DEPTH];
   logic [NET_LAT-1:0] vpipe_q;
   logic [IDX_W-1:0] ipipe_q [NET_LAT];
   logic [SEL_W-1:0] l_sel, r_sel;
   logic [Z-2:0]     m_sel;
   logic             wr_ok_d, len_ok_d, start_ok_d, issue_d, last_d, cfg_err_d;

   assign wr_ok_d    = cfg_we_i && state_q == IDLE && {1'b0, cfg_shift_i} < (SEL_W+1)'(Z);
   assign len_ok_d   = cfg_len_i != '0 && cfg_len_i <= (IDX_W+1)'(DEPTH);
   assign start_ok_d = start_i && state_q == IDLE && len_ok_d;
   // a start arriving while busy is dropped without an error
   assign cfg_err_d  = (cfg_we_i && !wr_ok_d) || (start_i && state_q == IDLE && !len_ok_d);
   assign issue_d    = state_q == ISSUE && issue_en_i;
   assign last_d     = {1'b0, ptr_q} == len_q - 1'b1;

   assign out_valid_o = vpipe_q[NET_LAT-1];
   assign out_idx_o   = ipipe_q[NET_LAT-1];

   // table has no reset; software reloads it after reset
   always_ff @(posedge sys_clk)
      if (wr_ok_d) tbl_q[cfg_addr_i] <= cfg_shift_i;

   qsn_sel_gen u_sel_gen (
      .shift_i     (tbl_q[ptr_q]),
      .left_sel_o  (l_sel),
      .right_sel_o (r_sel),
      .merge_sel_o (m_sel)
   );

   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         len_q       <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         cfg_err_o   <= 1'b0;
         in_valid_o  <= 1'b0;
         in_idx_o    <= '0;
         left_sel_o  <= '0;
         right_sel_o <= '0;
         merge_sel_o <= '0;
         vpipe_q     <= '0;
         ipipe_q     <= '{default: '0};
      end else begin
         cfg_err_o  <= cfg_err_d;
         in_valid_o <= issue_d;
         // done lands with the last output; FSM stays in DRAIN one more cycle so busy covers it
         done_o     <= state_q == DRAIN && cnt_q == CNT_W'(NET_LAT - 1);
         vpipe_q    <= NET_LAT'({vpipe_q, in_valid_o});
         ipipe_q[0] <= in_idx_o;
         for (int i = 1; i < NET_LAT; i++) ipipe_q[i] <= ipipe_q[i-1];
         if (issue_d) begin
            in_idx_o    <= ptr_q;
            left_sel_o  <= l_sel;
            right_sel_o <= r_sel;
            merge_sel_o <= m_sel;
            ptr_q       <= ptr_q + 1'b1;
         end
         case (state_q)
            IDLE: if (start_ok_d) begin
               state_q <= ISSUE;
               busy_o  <= 1'b1;
               len_q   <= cfg_len_i;
               ptr_q   <= '0;
            end
            ISSUE: if (issue_d && last_d) begin
               state_q <= DRAIN;
               cnt_q   <= '0;
            end
            DRAIN: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(NET_LAT)) begin
                  state_q <= IDLE;
                  busy_o  <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_qsn_shift_scheduler.sv
// tb_qsn_shift_scheduler: directed and random checks of the shift scheduler against a schedule model
module tb_qsn_shift_scheduler;
   import qsn_pkg::*;

   logic             sys_clk = 1'b0;
   logic             rstn = 1'b0;
   logic             cfg_we = 1'b0;
   logic [IDX_W-1:0] cfg_addr = '0;
   logic [SEL_W-1:0] cfg_shift = '0;
   logic [IDX_W:0]   cfg_len = '0;
   logic             start = 1'b0;
   logic             issue_en = 1'b0;
   logic             busy, done, cfg_err, in_valid, out_valid;
   logic [IDX_W-1:0] in_idx, out_idx;
   logic [SEL_W-1:0] left_sel, right_sel;
   logic [Z-2:0]     merge_sel;

   qsn_shift_scheduler dut (
      .sys_clk     (sys_clk),
      .rstn        (rstn),
      .cfg_we_i    (cfg_we),
      .cfg_addr_i  (cfg_addr),
      .cfg_shift_i (cfg_shift),
      .cfg_len_i   (cfg_len),
      .start_i     (start),
      .issue_en_i  (issue_en),
      .busy_o      (busy),
      .done_o      (done),
      .cfg_err_o   (cfg_err),
      .in_valid_o  (in_valid),
      .in_idx_o    (in_idx),
      .left_sel_o  (left_sel),
      .right_sel_o (right_sel),
      .merge_sel_o (merge_sel),
      .out_valid_o (out_valid),
      .out_idx_o   (out_idx)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // merge mask from the shift: ones in bits below Z-s, all ones for s=0
   function automatic logic [Z-2:0] mask_of(int s);
      logic [Z-2:0] one = 1;
      return (s == 0) ? {(Z-1){1'b1}} : (one << (Z - s)) - one;
   endfunction

   // schedule model: table contents, current run, and a ring of issued entries by cycle
   int  tbl_m [DEPTH];
   bit  m_run = 0, m_ok = 0;
   int  m_len = 0, m_issued = 0, m_last = -100, cyc = 0;
   bit  e_busy, e_done, e_err, e_iv, e_ov;
   int  e_idx, e_l, e_r, e_oi;
   logic [Z-2:0] e_m;
   bit  hv [8];
   int  hi [8];

   always @(posedge sys_clk) begin
      bit was;
      int s;
      cyc++;
      if (!rstn) begin
         m_run = 0; m_last = -100;
         e_busy = 0; e_done = 0; e_err = 0; e_iv = 0; e_ov = 0;
         e_idx = 0; e_l = 0; e_r = 0; e_oi = 0; e_m = '0;
         hv[cyc % 8] = 0; hv[(cyc + 7) % 8] = 0;
      end else begin
         was = m_run;
         e_err = (cfg_we && (was || cfg_shift >= Z)) || (start && !was && !(cfg_len inside {[1:DEPTH]}));
         e_iv = 0;
         if (m_run && m_issued < m_len && issue_en) begin
            s = tbl_m[m_issued];
            e_iv = 1; e_idx = m_issued; e_l = s; e_r = (Z - s) % Z; e_m = mask_of(s);
            m_issued++;
            if (m_issued == m_len) m_last = cyc;
         end
         e_done = (m_last == cyc - NET_LAT);
         if (m_run && m_last >= 0 && cyc == m_last + NET_LAT + 1) m_run = 0;
         if (cfg_we && !was && cfg_shift < Z) tbl_m[cfg_addr] = int'(cfg_shift);
         if (start && !was && cfg_len inside {[1:DEPTH]}) begin
            m_run = 1; m_len = int'(cfg_len); m_issued = 0; m_last = -100;
         end
         e_busy = m_run;
         hv[cyc % 8] = e_iv; hi[cyc % 8] = e_idx;
         e_ov = hv[(cyc + 8 - NET_LAT) % 8]; e_oi = hi[(cyc + 8 - NET_LAT) % 8];
      end
      m_ok = 1;
   end

   always @(negedge sys_clk) if (m_ok) begin
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("cfg_err", cfg_err, e_err);
      chk("in_valid", in_valid, e_iv);
      chk("in_idx", in_idx, e_idx);
      chk("left_sel", left_sel, e_l);
      chk("right_sel", right_sel, e_r);
      chk("merge_sel", merge_sel, e_m);
      chk("out_valid", out_valid, e_ov);
      if (e_ov) chk("out_idx", out_idx, e_oi);
   end

   task automatic drv(bit we, int addr, int sh, int len, bit st, bit en, bit rn);
      @(negedge sys_clk);
      rstn = rn; cfg_we = we; cfg_addr = addr[IDX_W-1:0]; cfg_shift = sh[SEL_W-1:0];
      cfg_len = len[IDX_W:0]; start = st; issue_en = en;
   endtask

   task automatic idle(bit en);
      drv(0, 0, 0, 0, 0, en, 1);
   endtask

   initial begin
      int v5, dcnt, done_at, n, first_iv, last_iv;
      logic [9:0] ivm;
      logic [Z-2:0] m100 = {{99{1'b0}}, {155{1'b1}}};
      logic [Z-2:0] m254 = 1;
      repeat (2) drv(0, 0, 0, 0, 0, 0, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_valid", in_valid, 0);
      chk("rst_merge", merge_sel, 0);
      v5 = 0;
      for (int i = 0; i < DEPTH; i++) begin
         n = $urandom_range(0, Z - 1);
         if (i == 5) v5 = n;
         drv(1, i, n, 0, 0, 0, 1);
      end
      drv(1, 0, 0, 0, 0, 0, 1);
      drv(1, 1, 100, 0, 0, 0, 1);
      drv(1, 2, 254, 0, 0, 0, 1);
      // select values, no stall
      drv(0, 0, 0, 3, 1, 1, 1);
      idle(1);
      idle(1);
      chk("sel0_valid", in_valid, 1); chk("sel0_idx", in_idx, 0);
      chk("sel0_left", left_sel, 0); chk("sel0_right", right_sel, 0); chk("sel0_merge", merge_sel, {(Z-1){1'b1}});
      idle(1);
      chk("sel100_left", left_sel, 100); chk("sel100_right", right_sel, 155); chk("sel100_merge", merge_sel, m100);
      idle(1);
      chk("sel254_left", left_sel, 254); chk("sel254_right", right_sel, 1); chk("sel254_merge", merge_sel, m254);
      chk("out0_valid", out_valid, 1); chk("out0_idx", out_idx, 0);
      idle(1);
      chk("out1_idx", out_idx, 1); chk("done_early", done, 0);
      idle(1);
      chk("done_t5", done, 1); chk("out2_idx", out_idx, 2); chk("busy_at_done", busy, 1);
      idle(1);
      chk("busy_fall", busy, 0);
      // stall after first issue
      drv(0, 0, 0, 3, 1, 1, 1);
      ivm = '0; done_at = -1;
      for (int j = 0; j < 10; j++) begin
         idle(!(j == 1 || j == 2));
         ivm[j] = in_valid;
         if (done) done_at = j;
      end
      chk("stall_iv_pattern", ivm, 10'b0000110010);
      chk("stall_done_at", done_at, 7);
      // rejected configuration
      drv(1, 5, 255, 0, 0, 0, 1);
      drv(0, 0, 0, 0, 1, 0, 1);
      chk("bad_shift_err", cfg_err, 1);
      idle(0);
      chk("len0_err", cfg_err, 1); chk("len0_busy", busy, 0);
      drv(0, 0, 0, 17, 1, 0, 1);
      idle(0);
      chk("len17_err", cfg_err, 1); chk("len17_busy", busy, 0);
      // busy interactions
      drv(0, 0, 0, 4, 1, 1, 1);
      idle(1);
      drv(1, 1, 77, 0, 0, 1, 1);
      drv(0, 0, 0, 5, 1, 1, 1);
      chk("busy_write_err", cfg_err, 1);
      dcnt = 0;
      for (int j = 0; j < 10; j++) begin
         idle(1);
         if (j == 0) chk("busy_start_no_err", cfg_err, 0);
         if (done) dcnt++;
      end
      chk("busy_one_done", dcnt, 1);
      // reset mid-run after two issues
      drv(0, 0, 0, 8, 1, 1, 1);
      idle(1);
      idle(1);
      drv(0, 0, 0, 0, 0, 1, 0);
      idle(1);
      chk("rstmid_busy", busy, 0); chk("rstmid_in_valid", in_valid, 0); chk("rstmid_left", left_sel, 0);
      chk("rstmid_merge", merge_sel, 0); chk("rstmid_out_valid", out_valid, 0);
      dcnt = 0;
      for (int j = 0; j < 6; j++) begin
         idle(1);
         if (done) dcnt++;
      end
      chk("rstmid_no_done", dcnt, 0);
      drv(0, 0, 0, 3, 1, 1, 1);
      idle(1);
      idle(1);
      chk("rerun_first_idx", in_idx, 0); chk("rerun_first_valid", in_valid, 1);
      repeat (6) idle(1);
      // full depth back-to-back
      drv(0, 0, 0, DEPTH, 1, 1, 1);
      n = 0; first_iv = -1; last_iv = -1; done_at = -1;
      for (int j = 0; j < 25; j++) begin
         idle(1);
         if (in_valid) begin
            chk("full_idx", in_idx, n);
            if (n == 1) chk("full_tbl1_kept", left_sel, 100);
            if (n == 5) chk("full_tbl5_kept", left_sel, v5);
            if (first_iv < 0) first_iv = j;
            last_iv = j;
            n++;
         end
         if (done) done_at = j;
      end
      chk("full_count", n, DEPTH);
      chk("full_contiguous", last_iv - first_iv + 1, DEPTH);
      chk("full_done_lat", done_at - last_iv, NET_LAT);
      // randomized traffic against the model
      for (int j = 0; j < 600; j++)
         drv($urandom_range(0, 4) == 0, $urandom_range(0, DEPTH - 1),
             ($urandom_range(0, 7) == 0) ? Z : $urandom_range(0, Z - 1),
             $urandom_range(0, DEPTH + 1), $urandom_range(0, 6) == 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 99) != 0);
      repeat (25) idle(1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
